tap2bpm: RTL



---
 rtl/tap2bpm_if.sv | 23 ++
 rtl/tap2bpm.sv | 110 +++++++++++
 2 files changed

// File: rtl/tap2bpm_if.sv
// Period-in / BPM-out handshake between the tap-period counter, tap2bpm and the PWM generator.
interface tap2bpm_if #(
  parameter int unsigned PER_WIDTH = 12,
  parameter int unsigned BPM_MAX   = 250
);
  localparam int unsigned BPMW = $clog2(BPM_MAX + 1);

  logic [PER_WIDTH-1:0] per_i;
  logic                 per_valid_i;
  logic [BPMW-1:0]      bpm_o;
  logic                 bpm_valid;
  logic                 busy_o;

  modport master (
    output per_i, per_valid_i,
    input  bpm_o, bpm_valid, busy_o
  );

  modport slave (
    input  per_i, per_valid_i,
    output bpm_o, bpm_valid, busy_o
  );
endinterface

// File: rtl/tap2bpm.sv
// Tap period to BPM converter: floor(TP_PER_MIN / per) via a one-bit-per-clock
// restoring divider, saturated to BPM_MAX.
module tap2bpm #(
  parameter int unsigned TP_PER_MIN = 60000,
  parameter int unsigned BPM_MAX    = 250,
  parameter int unsigned PER_WIDTH  = 12
) (
  input  logic      clk_i,
  input  logic      rst_i,
  tap2bpm_if.slave  bus
);
  localparam int unsigned BPMW    = $clog2(BPM_MAX + 1);
  localparam int unsigned DW      = $clog2(TP_PER_MIN + 1);
  localparam int unsigned PER_MIN = TP_PER_MIN / BPM_MAX;
  localparam int unsigned REMW    = PER_WIDTH + 1;
  localparam int unsigned CNTW    = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [PER_WIDTH-1:0] r_per,   w_per_nxt;
  logic [REMW-1:0]      r_rem,   w_rem_nxt;
  logic [DW-1:0]        r_dvd,   w_dvd_nxt;
  logic [DW-1:0]        r_quot,  w_quot_nxt;
  logic [CNTW-1:0]      r_cnt,   w_cnt_nxt;
  logic [BPMW-1:0]      r_bpm,   w_bpm_nxt;
  logic                 r_bpm_valid;
  logic                 r_busy;
  logic [REMW:0]        w_trial;
  logic                 w_qbit;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_per_nxt   = r_per;
    w_rem_nxt   = r_rem;
    w_dvd_nxt   = r_dvd;
    w_quot_nxt  = r_quot;
    w_cnt_nxt   = r_cnt;
    w_bpm_nxt   = r_bpm;
    w_trial     = {r_rem, r_dvd[DW-1]};
    w_qbit      = (w_trial >= (REMW + 1)'(r_per));

    case (r_state)
      IDLE: begin
        if (bus.per_valid_i) begin
          w_per_nxt   = bus.per_i;
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        // Short periods (and zero) would exceed BPM_MAX anyway; skip the divide.
        if (r_per < PER_WIDTH'(PER_MIN)) begin
          w_bpm_nxt   = BPMW'(BPM_MAX);
          w_state_nxt = DONE;
        end else begin
          w_rem_nxt   = '0;
          w_dvd_nxt   = DW'(TP_PER_MIN);
          w_quot_nxt  = '0;
          w_cnt_nxt   = CNTW'(DW - 1);
          w_state_nxt = DIV;
        end
      end
      DIV: begin
        // Remainder stays below per, so the trial always fits REMW bits.
        w_rem_nxt  = w_qbit ? REMW'(w_trial - (REMW + 1)'(r_per)) : REMW'(w_trial);
        w_dvd_nxt  = r_dvd << 1;
        w_quot_nxt = DW'({r_quot, w_qbit});
        w_cnt_nxt  = r_cnt - CNTW'(1);
        if (r_cnt == '0) begin
          w_bpm_nxt   = (w_quot_nxt > DW'(BPM_MAX)) ? BPMW'(BPM_MAX) : BPMW'(w_quot_nxt);
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers; valid/busy follow the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_per       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_quot      <= '0;
      r_cnt       <= '0;
      r_bpm       <= '0;
      r_bpm_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_per       <= w_per_nxt;
      r_rem       <= w_rem_nxt;
      r_dvd       <= w_dvd_nxt;
      r_quot      <= w_quot_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bpm       <= w_bpm_nxt;
      r_bpm_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign bus.bpm_o     = r_bpm;
  assign bus.bpm_valid = r_bpm_valid;
  assign bus.busy_o    = r_busy;
endmodule
